if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue entry count; legal values are powers of two, 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 start_i  in  1  fetch enable; while 0, no new requests are issued.
REQ-006 redirect_i  in  1  flush the queue and restart fetch at redirect_pc_i (branch, jal or jalr taken).
REQ-007 redirect_pc_i  in  32  new fetch address; bit 0 is ignored.
REQ-008 stall_i  in  1  IF/ID hold; the head entry is not consumed.
REQ-009 imem_req_o  out  1  request valid, held until the response arrives.
REQ-010 imem_addr_o  out  32  request address, stable while imem_req_o=1.
REQ-011 imem_valid_i  in  1  response valid; may assert in the request cycle (zero-wait) or later.
REQ-012 imem_data_i  in  32  instruction word, qualified by imem_valid_i.
REQ-013 valid_o  out  1  head entry valid.
REQ-014 pc_o / inst_o  out  32/32  PC and instruction of the head entry.

Function
REQ-015 FSM states: IDLE (before start_i) -> RUN -> DRAIN (response pending after a redirect) -> RUN.
REQ-016 A consume SHALL occur when valid_o=1 and stall_i=0; the head advances on that edge.
REQ-017 In RUN, the block SHALL issue a request only when count + outstanding < DEPTH; at most one request is outstanding.
REQ-018 A response SHALL be enqueued with {fetch_pc, imem_data_i}; fetch_pc then advances by 4 (mod 2^32) and a new request may start in the next cycle.
REQ-019 valid_o SHALL equal (count != 0) and be fully registered; an enqueued word becomes visible one cycle after its imem_valid_i cycle.
REQ-020 Enqueue and consume in the same cycle SHALL leave count unchanged, including when the queue is full.
REQ-021 When full and not consuming, imem_req_o SHALL be 0.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-023 On redirect_i, the queue SHALL be emptied and fetch_pc set to {redirect_pc_i[31:1],1'b0}; valid_o SHALL be 0 in the next cycle.
REQ-024 If a request is outstanding at redirect_i and its response is not in the same cycle, the FSM SHALL enter DRAIN and discard exactly one response, with imem_req_o=0 meanwhile.
REQ-025 A response arriving in the redirect cycle SHALL be discarded; redirect takes priority over consume and enqueue.
REQ-026 With no request outstanding, the request to the new PC SHALL be asserted in the cycle after redirect_i.
REQ-027 Deasserting start_i SHALL stop new requests; an outstanding request SHALL still complete and be enqueued.

Reset
REQ-028 rst_i SHALL force on the next edge: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, outstanding=0, valid_o=0, imem_req_o=0, imem_addr_o=RESET_PC, pc_o=0, inst_o=0.
REQ-029 Reset during an outstanding request SHALL drop that request; a response arriving after reset SHALL be ignored unless imem_req_o=1.

Structure
REQ-030 The shared CPU package SHALL hold the FSM state enum, NOP_INSTR (32'h0000_0013) and RESET_PC.
REQ-031 Queue storage SHALL be one sub-module, pf_fifo (synchronous FIFO with flush, push, pop, count and head output); the FSM and PC logic live in if_prefetch.

Verification
REQ-032 Zero-wait memory, start_i=1, stall_i=0 -> pc_o sequence 0,4,8,12 with one entry per cycle after the first fill.
REQ-033 3-cycle latency memory, DEPTH=4, stall_i=1 for 20 cycles -> count reaches 4, imem_req_o=0, no entry lost; after release, 4 consecutive consumes of PCs 0..12.
REQ-034 Redirect to 32'h0000_0101 while a response is pending -> stale word discarded, next pc_o=32'h0000_0100.
REQ-035 redirect_i coincident with imem_valid_i and a consume -> queue empty next cycle, valid_o=0, a request to the new PC in the following cycle.
REQ-036 rst_i pulsed mid-fetch with count=3 -> all outputs at reset values next cycle; first request to RESET_PC after start_i.
REQ-037 fetch_pc=32'hFFFF_FFFC enqueued -> next imem_addr_o=32'h0000_0000 (wrap-around).

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg: shared CPU fetch types and constants.
package if_prefetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} pf_state_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_prefetch_fifo.sv
// pf_fifo: synchronous FIFO with flush, registered non-empty flag and combinational head.
module pf_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [W-1:0]            data_i,
    output logic [W-1:0]            head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    valid_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;
    always_comb begin
        do_pop = pop_i && count_q != '0;
        do_push = push_i && (count_q != (AW+1)'(DEPTH) || do_pop);
        count_d = flush_i ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
            valid_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= flush_i ? '0 : wr_q + AW'(do_push);
            rd_q <= flush_i ? '0 : rd_q + AW'(do_pop);
            count_q <= count_d;
            valid_o <= count_d != '0;
            if (do_push && !flush_i) mem_q[wr_q] <= data_i;
        end
    end
    assign head_o = mem_q[rd_q];
    assign count_o = count_q;
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch with a queue, redirect flush and stale-response drain.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [31:0] RESET_PC = if_prefetch_pkg::RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    pf_state_e state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic out_q, out_d, issue, push, pop;
    logic [CW-1:0] count;
    logic [63:0] head;
    // A fresh request never starts in a redirect cycle, so only out_q can be in flight across it.
    always_comb begin
        issue = state_q == RUN && start_i && !out_q && !redirect_i && count < CW'(DEPTH);
        imem_req_o = state_q == RUN && (out_q || issue);
        push = imem_req_o && imem_valid_i && !redirect_i;
        pop = valid_o && !stall_i;
        out_d = imem_req_o && !imem_valid_i && !redirect_i;
        fetch_pc_d = redirect_i ? {redirect_pc_i[31:1], 1'b0} : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
        state_d = state_q == IDLE ? (start_i ? RUN : IDLE)
                : state_q == RUN ? (redirect_i && out_q && !imem_valid_i ? DRAIN : RUN)
                : (imem_valid_i ? RUN : DRAIN);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            fetch_pc_q <= RESET_PC;
            out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q <= out_d;
        end
    end
    pf_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({fetch_pc_q, imem_data_i}),
        .head_o  (head),
        .count_o (count),
        .valid_o (valid_o)
    );
    assign imem_addr_o = fetch_pc_q;
    assign pc_o = head[63:32];
    assign inst_o = head[31:0];
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: vector table, directed corner sequences and a randomized queue-model run.
module tb_if_prefetch;
    import if_prefetch_pkg::*;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst_i, start_i, redirect_i, stall_i, imem_valid_i, imem_req_o, valid_o;
    logic [31:0] redirect_pc_i, imem_data_i, imem_addr_o, pc_o, inst_o;
    int n_cmp, n_err, mem_cnt, lat;
    bit mem_pend, rand_lat, drain, found;
    logic [31:0] mem_addr, fpc;
    logic [31:0] mq[$];

    typedef struct {
        bit start, stall, redir;
        logic [31:0] rpc;
        bit valid;
        logic [31:0] pc;
        bit req;
        logic [31:0] addr;
    } vec_t;
    vec_t tbl [17];

    always #5 clk = ~clk;

    if_prefetch #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .stall_i(stall_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
        .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    // Memory: latches a request, answers after lat cycles even if the request is dropped.
    function automatic void mem_eval();
        imem_valid_i = 1'b0;
        imem_data_i = '0;
        if (!mem_pend && imem_req_o && !rst_i) begin
            mem_pend = 1'b1;
            mem_addr = imem_addr_o;
            mem_cnt = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end
        if (mem_pend && mem_cnt >= lat) begin
            imem_valid_i = 1'b1;
            imem_data_i = word(mem_addr);
        end
    endfunction

    task automatic drive(input bit s, input bit st, input bit rd, input logic [31:0] rpc);
        start_i = s;
        stall_i = st;
        redirect_i = rd;
        redirect_pc_i = rpc;
        #1;
        mem_eval();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (imem_valid_i) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt++;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (5) begin
            drive(0, 0, 0, 0);
            tick();
        end
        rst_i = 1'b0;
        mem_pend = 1'b0;
        rand_lat = 1'b0;
        lat = 0;
    endtask

    function automatic void model_step();
        check("valid", valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            check("head_pc", pc_o, mq[0]);
            check("head_inst", inst_o, word(mq[0]));
        end
        if (drain) check("drain_req", imem_req_o, 0);
        if (mq.size() == DEPTH) check("full_req", imem_req_o, 0);
        if (mem_pend && !drain) check("held_req", imem_req_o, 1);
        if (imem_req_o) check("req_addr", imem_addr_o, fpc);
        if (redirect_i) begin
            mq.delete();
            fpc = redirect_pc_i & 32'hFFFF_FFFE;
            drain = mem_pend && !imem_valid_i;
        end else begin
            if (valid_o && !stall_i && mq.size() != 0) void'(mq.pop_front());
            if (imem_valid_i) begin
                if (drain) drain = 1'b0;
                else begin
                    mq.push_back(fpc);
                    fpc = fpc + 32'd4;
                end
            end
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        mem_pend = 0;
        rand_lat = 0;
        lat = 0;
        tbl = '{
            '{1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0},
            '{1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0},
            '{1, 0, 0, 32'h0,         1, 32'h0,         1, 32'h4},
            '{1, 0, 0, 32'h0,         1, 32'h4,         1, 32'h8},
            '{1, 1, 0, 32'h0,         1, 32'h8,         1, 32'hC},
            '{1, 1, 0, 32'h0,         1, 32'h8,         1, 32'h10},
            '{1, 1, 0, 32'h0,         1, 32'h8,         1, 32'h14},
            '{1, 1, 0, 32'h0,         1, 32'h8,         0, 32'h18},
            '{1, 0, 0, 32'h0,         1, 32'h8,         0, 32'h18},
            '{1, 0, 0, 32'h0,         1, 32'hC,         1, 32'h18},
            '{1, 0, 1, 32'h101,       1, 32'h10,        0, 32'h1C},
            '{1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h100},
            '{1, 0, 0, 32'h0,         1, 32'h100,       1, 32'h104},
            '{1, 0, 1, 32'hFFFF_FFFC, 1, 32'h104,       0, 32'h108},
            '{1, 0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC},
            '{0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0},
            '{0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0}
        };

        do_reset();
        drive(0, 0, 0, 0);
        check("rst_valid", valid_o, 0);
        check("rst_req", imem_req_o, 0);
        check("rst_addr", imem_addr_o, RESET_PC);
        check("rst_pc", pc_o, 0);
        check("rst_inst", inst_o, 0);
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].start, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
            check($sformatf("tbl%0d_valid", i), valid_o, tbl[i].valid);
            check($sformatf("tbl%0d_req", i), imem_req_o, tbl[i].req);
            check($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].addr);
            if (tbl[i].valid) begin
                check($sformatf("tbl%0d_pc", i), pc_o, tbl[i].pc);
                check($sformatf("tbl%0d_inst", i), inst_o, word(tbl[i].pc));
            end
            tick();
        end

        // Slow memory, long stall: queue fills, requests stop, nothing is lost.
        do_reset();
        lat = 3;
        for (int c = 0; c < 20; c++) begin
            drive(1, 1, 0, 0);
            if (c == 19) begin
                check("stall_full_req", imem_req_o, 0);
                check("stall_valid", valid_o, 1);
                check("stall_head", pc_o, 0);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0);
            check($sformatf("drain_q%0d_valid", k), valid_o, 1);
            check($sformatf("drain_q%0d_pc", k), pc_o, 32'(4 * k));
            check($sformatf("drain_q%0d_inst", k), inst_o, word(32'(4 * k)));
            tick();
        end

        // Redirect while a response is pending: stale word discarded.
        do_reset();
        lat = 3;
        drive(1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0);
        check("pend_req", imem_req_o, 1);
        check("pend_addr", imem_addr_o, 0);
        tick();
        drive(1, 0, 1, 32'h0000_0101);
        check("pend_held", imem_req_o, 1);
        tick();
        drive(1, 0, 0, 0);
        check("drain_req0", imem_req_o, 0);
        check("drain_valid0", valid_o, 0);
        tick();
        drive(1, 0, 0, 0);
        check("drain_req1", imem_req_o, 0);
        tick();
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            drive(1, 1, 0, 0);
            if (valid_o) begin
                found = 1;
                check("redir_pc", pc_o, 32'h0000_0100);
                check("redir_inst", inst_o, word(32'h0000_0100));
            end
            tick();
        end
        if (!found) check("redir_timeout", 0, 1);

        // Redirect coincident with a response and a consume.
        do_reset();
        lat = 1;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (valid_o && mem_pend && mem_cnt >= lat) begin
                found = 1;
                drive(1, 0, 1, 32'h0000_0200);
                check("coin_resp", imem_valid_i, 1);
            end else drive(1, 1, 0, 0);
            tick();
        end
        if (!found) check("coin_timeout", 0, 1);
        drive(1, 0, 0, 0);
        check("coin_valid", valid_o, 0);
        check("coin_req", imem_req_o, 1);
        check("coin_addr", imem_addr_o, 32'h0000_0200);
        tick();

        // Reset mid-fetch with three entries queued and a request in flight.
        do_reset();
        lat = 2;
        for (int c = 0; c < 11; c++) begin
            drive(1, 1, 0, 0);
            if (c == 10) begin
                check("mid_valid", valid_o, 1);
                check("mid_req", imem_req_o, 1);
            end
            tick();
        end
        rst_i = 1'b1;
        drive(1, 1, 0, 0);
        tick();
        rst_i = 1'b0;
        drive(0, 0, 0, 0);
        check("mrst_valid", valid_o, 0);
        check("mrst_req", imem_req_o, 0);
        check("mrst_addr", imem_addr_o, RESET_PC);
        check("mrst_pc", pc_o, 0);
        check("mrst_inst", inst_o, 0);
        tick();
        drive(0, 0, 0, 0);
        check("stale_ignored", valid_o, 0);
        tick();
        drive(1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0);
        check("restart_req", imem_req_o, 1);
        check("restart_addr", imem_addr_o, RESET_PC);
        tick();

        // Randomized run against the queue model.
        do_reset();
        rand_lat = 1;
        mq.delete();
        fpc = RESET_PC;
        drain = 0;
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom());
            model_step();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
